// File: rtl/npu_cube_acc_ctrl.sv
// Carry-save accumulation sequencer behind the last adder-tree level: folds one
// (sum, carry) beat per handshake, then resolves the group with a single CPA.
module npu_cube_acc_ctrl #(
    parameter int DWIN      = 19,
    parameter int DWACC     = 24,
    parameter int SIGNED_IN = 0,
    parameter int MAX_DEPTH = 256,
    parameter int DWCNT     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DWIN-1:0]  in_sum,
    input  logic [DWIN-1:0]  in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DWACC-1:0] out_data,
    output logic [DWCNT-1:0] out_beats,
    output logic             out_ovf
);

    // Handshake: a beat (or result) transfers on a rising edge where valid and
    // ready are both high; valid-side payload must hold until that edge.

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

    localparam logic [DWCNT-1:0] DEPTH = DWCNT'(MAX_DEPTH);

    state_t           state_q, state_d;
    logic [DWACC-1:0] acc_s_q, acc_s_d;
    logic [DWACC-1:0] acc_c_q, acc_c_d;
    logic [DWCNT-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [DWACC-1:0] out_data_q, out_data_d;
    logic [DWCNT-1:0] out_beats_q, out_beats_d;
    logic             out_ovf_q, out_ovf_d;

    logic [DWACC-1:0] x, yc, y;
    logic [DWACC-1:0] fs, fc, fc2, s1, c1, c1_2, s2, c2;
    logic [DWCNT-1:0] cnt_next;
    logic             accept, close_depth;

    // Extend inputs to accumulator width; narrower accumulators simply truncate.
    for (genvar i = 0; i < DWACC; i++) begin : g_ext
        if (i < DWIN) begin : g_in
            assign x[i]  = in_sum[i];
            assign yc[i] = in_carry[i];
        end else begin : g_pad
            assign x[i]  = (SIGNED_IN != 0) ? in_sum[DWIN-1]   : 1'b0;
            assign yc[i] = (SIGNED_IN != 0) ? in_carry[DWIN-1] : 1'b0;
        end
    end
    assign y = yc << 1;

    // Two 3:2 stages; the stored carry vector lives at weight 2.
    always_comb begin
        fs   = (state_q == IDLE) ? '0 : acc_s_q;
        fc   = (state_q == IDLE) ? '0 : acc_c_q;
        fc2  = fc << 1;
        s1   = fs ^ fc2 ^ x;
        c1   = (fs & fc2) | (fs & x) | (fc2 & x);
        c1_2 = c1 << 1;
        s2   = s1 ^ c1_2 ^ y;
        c2   = (s1 & c1_2) | (s1 & y) | (c1_2 & y);
    end

    assign accept      = in_valid & in_ready_q;
    assign cnt_next    = (state_q == IDLE) ? DWCNT'(1) : cnt_q + DWCNT'(1);
    assign close_depth = (cnt_next == DEPTH);

    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    acc_s_d = s2;
                    acc_c_d = c2;
                    cnt_d   = cnt_next;
                    if (in_last || close_depth) begin
                        state_d    = RESOLVE;
                        in_ready_d = 1'b0;
                        ovf_pend_d = close_depth & ~in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            RESOLVE: begin
                out_data_d  = acc_s_q + (acc_c_q << 1);
                out_beats_d = cnt_q;
                out_ovf_d   = ovf_pend_q;
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_s_d     = '0;
                    acc_c_d     = '0;
                    cnt_d       = '0;
                    ovf_pend_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

endmodule
